// File: rtl/run_event_pkg.sv
// Shared types and defaults for the run-event counter: FSM states, detect codes
// and the 2-digit BCD count type with its saturating increment.
package run_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [3:0] ZERO_CODE_DEF = 4'h4;
  localparam logic [3:0] ONE_CODE_DEF  = 4'h8;
  localparam logic [3:0] DWELL_MAX_DEF = 4'd15;

  typedef logic [7:0] bcd2_t;

  // Ones digit wraps 9 -> 0 with carry into tens; the whole count sticks at 99.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/run_event_counter_bcd.sv
// Two-digit BCD event counter, saturating at 99, with synchronous clear.
module bcd_counter2
  import run_event_pkg::*;
(
  input  logic  Clock,
  input  logic  Reset,
  input  logic  Clear,
  input  logic  Inc,
  output bcd2_t Count
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)      Count <= 8'h00;
    else if (Clear) Count <= 8'h00;
    else if (Inc)   Count <= bcd2_inc(Count);
  end

endmodule

// File: rtl/run_event_counter.sv
// Counts zeros-run and ones-run detections from the run-detector FSM, tracks
// dwell of the active detection and flags z high with an illegal state code.
module run_event_counter
  import run_event_pkg::*;
#(
  parameter logic [3:0] ZERO_CODE = ZERO_CODE_DEF,
  parameter logic [3:0] ONE_CODE  = ONE_CODE_DEF,
  parameter logic [3:0] DWELL_MAX = DWELL_MAX_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Clear,
  input  logic       z,
  input  logic [3:0] y,
  output logic [7:0] ZeroCount,
  output logic [7:0] OneCount,
  output logic [3:0] Dwell,
  output logic       Event,
  output logic       LastType,
  output logic       Error,
  output state_t     DebugState
);

  logic       z_q;
  logic [3:0] y_q;
  state_t     state_q, state_d;
  logic [3:0] dwell_q, dwell_d;
  logic       event_q, event_d;
  logic       last_q, last_d;
  logic       error_q, error_d;
  logic       legal, new_det;
  logic       inc_zero, inc_one;

  assign legal   = (y == ZERO_CODE) || (y == ONE_CODE);
  assign new_det = z && (!z_q || (y != y_q));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      z_q     <= 1'b0;
      y_q     <= 4'h0;
      state_q <= IDLE;
      dwell_q <= 4'd0;
      event_q <= 1'b0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      z_q     <= z;
      y_q     <= y;
      state_q <= state_d;
      dwell_q <= dwell_d;
      event_q <= event_d;
      last_q  <= last_d;
      error_q <= error_d;
    end
  end

  // Holding the defaults while Enable is low freezes everything except history.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    event_d  = 1'b0;
    last_d   = last_q;
    error_d  = error_q;
    inc_zero = 1'b0;
    inc_one  = 1'b0;
    if (Clear) begin
      state_d = IDLE;
      dwell_d = 4'd0;
      error_d = 1'b0;
    end else if (Enable) begin
      if (!z) begin
        state_d = IDLE;
        dwell_d = 4'd0;
      end else if (!legal) begin
        state_d = FAULT;
        dwell_d = 4'd0;
        error_d = 1'b1;
      end else if (new_det) begin
        state_d = ACTIVE;
        dwell_d = 4'd1;
        event_d = 1'b1;
        if (y == ONE_CODE) begin
          inc_one = 1'b1;
          last_d  = 1'b1;
        end else begin
          inc_zero = 1'b1;
          last_d   = 1'b0;
        end
      end else begin
        // Continuing run: only a counted detection accumulates dwell.
        case (state_q)
          ACTIVE:  if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 4'd1;
          default: dwell_d = 4'd0;
        endcase
      end
    end
  end

  bcd_counter2 u_zero_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (Clear),
    .Inc   (inc_zero),
    .Count (ZeroCount)
  );

  bcd_counter2 u_one_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (Clear),
    .Inc   (inc_one),
    .Count (OneCount)
  );

  assign Dwell      = dwell_q;
  assign Event      = event_q;
  assign LastType   = last_q;
  assign Error      = error_q;
  assign DebugState = state_q;

endmodule
